// File: rtl/imm_pkg.sv
// Shared types and constants for the pipelined immediate generator.
//   imm_src_e    : 3-bit immediate format select
//   stage_meta_t : per-stage control payload {valid, illegal}
//   CNT_W        : width of the illegal-select counter
package imm_pkg;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned INSTR_W = 25;  // instruction bits [31:7]

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_J   = 3'b011,
    IMM_U   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_BAD = 3'b111
  } imm_src_e;

  typedef struct packed {
    logic valid;
    logic illegal;
  } stage_meta_t;

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational immediate decoder: selects the format and extends to XLEN.
//   instr_i   : instruction bits [31:7] (instr_i[k] == instr[k+7])
//   sel_i     : format select
//   immext_o  : extended immediate
//   illegal_o : select was IMM_BAD
module imm_ext_comb
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr_i,
  input  imm_src_e           sel_i,
  output logic [XLEN-1:0]    immext_o,
  output logic               illegal_o
);

  // Sized casts of signed operands sign-extend; of unsigned ones zero-extend.
  always_comb begin
    immext_o  = '0;
    illegal_o = 1'b0;
    case (sel_i)
      IMM_I:   immext_o = XLEN'($signed(instr_i[24:13]));
      IMM_S:   immext_o = XLEN'($signed({instr_i[24:18], instr_i[4:0]}));
      IMM_B:   immext_o = XLEN'($signed({instr_i[24], instr_i[0], instr_i[23:18],
                                         instr_i[4:1], 1'b0}));
      IMM_J:   immext_o = XLEN'($signed({instr_i[24], instr_i[12:5], instr_i[13],
                                         instr_i[23:14], 1'b0}));
      IMM_U:   immext_o = XLEN'($signed({instr_i[24:5], 12'b0}));
      IMM_Z:   immext_o = XLEN'(instr_i[12:8]);
      IMM_SH: begin
        // RV64 shift amounts use one extra bit (instr[25]).
        if (XLEN == 64) immext_o = XLEN'(instr_i[18:13]);
        else            immext_o = XLEN'(instr_i[17:13]);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with an elastic valid/ready register chain.
//   clk, reset_n          : clock, async active-low reset
//   in_valid/in_ready     : input handshake (in_ready is combinational)
//   in_instr/in_immsrc    : instruction bits [31:7] and format select
//   in_tag                : opaque sideband carried with the beat
//   flush                 : kills all in-flight beats and the current input beat
//   out_valid/out_ready   : output handshake
//   out_immext/out_tag    : extended immediate and its tag
//   out_illegal           : beat carried select 3'b111
//   illegal_cnt           : saturating count of accepted illegal beats
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned TAG_W  = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [2:0]         in_immsrc,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_immext,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   illegal_cnt
);

  // Index 0 is the combinational entry point; index g+1 is the output of stage g.
  logic             vld_a [STAGES+1];
  logic [XLEN-1:0]  imm_a [STAGES+1];
  logic [TAG_W-1:0] tag_a [STAGES+1];
  logic             ill_a [STAGES+1];
  logic             ld_a  [STAGES];

  logic             accept;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  imm_ext_comb #(.XLEN(XLEN)) u_ext (
    .instr_i   (in_instr),
    .sel_i     (imm_src_e'(in_immsrc)),
    .immext_o  (imm_a[0]),
    .illegal_o (ill_a[0])
  );

  // A beat presented together with flush is dropped at the door.
  assign vld_a[0] = in_valid && !flush;
  assign tag_a[0] = in_tag;

  // Load enables ripple backwards from out_ready: a stage loads when empty or
  // when the stage after it is loading this cycle.
  always_comb begin : ready_chain
    logic take;
    ld_a = '{default: 1'b0};
    take = out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      ld_a[i] = !vld_a[i+1] || take;
      take    = ld_a[i];
    end
  end

  for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
    stage_meta_t      meta_q;
    logic [XLEN-1:0]  imm_q;
    logic [TAG_W-1:0] tag_q;

    // Data only captures real beats so empty stages keep their old contents.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        meta_q <= '0;
        imm_q  <= '0;
        tag_q  <= '0;
      end else begin
        if (flush)         meta_q.valid <= 1'b0;
        else if (ld_a[g])  meta_q.valid <= vld_a[g];
        if (ld_a[g] && vld_a[g]) begin
          imm_q          <= imm_a[g];
          tag_q          <= tag_a[g];
          meta_q.illegal <= ill_a[g];
        end
      end
    end

    assign vld_a[g+1] = meta_q.valid;
    assign imm_a[g+1] = imm_q;
    assign tag_a[g+1] = tag_q;
    assign ill_a[g+1] = meta_q.illegal;
  end

  assign accept = vld_a[0] && ld_a[0];

  // Saturating illegal-select counter; flush does not touch it.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && ill_a[0] && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign in_ready    = ld_a[0];
  assign out_valid   = vld_a[STAGES];
  assign out_immext  = imm_a[STAGES];
  assign out_tag     = tag_a[STAGES];
  assign out_illegal = ill_a[STAGES];
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: instance A (XLEN=32, STAGES=1) and B (XLEN=64, STAGES=3).
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  logic        a_in_valid = 0, a_in_ready, a_flush = 0, a_out_valid, a_out_ready = 1, a_out_illegal;
  logic [24:0] a_in_instr = '0;
  logic [2:0]  a_in_immsrc = '0;
  logic [4:0]  a_in_tag = '0, a_out_tag;
  logic [31:0] a_out_immext;
  logic [15:0] a_illegal_cnt;

  logic        b_in_valid = 0, b_in_ready, b_flush = 0, b_out_valid, b_out_ready = 1, b_out_illegal;
  logic [24:0] b_in_instr = '0;
  logic [2:0]  b_in_immsrc = '0;
  logic [4:0]  b_in_tag = '0, b_out_tag;
  logic [63:0] b_out_immext;
  logic [15:0] b_illegal_cnt;

  imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(5)) u_a (
    .clk(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_in_instr), .in_immsrc(a_in_immsrc), .in_tag(a_in_tag), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_immext(a_out_immext),
    .out_tag(a_out_tag), .out_illegal(a_out_illegal), .illegal_cnt(a_illegal_cnt));

  imm_gen_pipe #(.XLEN(64), .STAGES(3), .TAG_W(5)) u_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_immsrc(b_in_immsrc), .in_tag(b_in_tag), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_immext(b_out_immext),
    .out_tag(b_out_tag), .out_illegal(b_out_illegal), .illegal_cnt(b_illegal_cnt));

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } sb_t;

  sb_t qa[$];
  sb_t qb[$];

  // Reference immediate from the full 32-bit instruction word.
  function automatic logic [63:0] model(input logic [24:0] ins, input logic [2:0] sel, input bit is64);
    logic [31:0] i;
    logic [63:0] v;
    i = {ins, 7'b0};
    case (sel)
      3'd0: v = {{52{i[31]}}, i[31:20]};
      3'd1: v = {{52{i[31]}}, i[31:25], i[11:7]};
      3'd2: v = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: v = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4: v = {{32{i[31]}}, i[31:12], 12'b0};
      3'd5: v = {59'b0, i[19:15]};
      3'd6: v = is64 ? {58'b0, i[25:20]} : {59'b0, i[24:20]};
      default: v = '0;
    endcase
    if (!is64) v = {32'b0, v[31:0]};
    return v;
  endfunction

  // Scoreboard A: pop/compare on output handshake, push on accepted input.
  always @(negedge clk) begin
    if (!reset_n) qa.delete();
    else begin
      if (a_out_valid && a_out_ready) begin
        total++;
        if (qa.size() == 0) begin
          bad++;
          $display("FAIL a_unexpected_beat: got imm=%h tag=%0d, required no beat", a_out_immext, a_out_tag);
        end else begin
          sb_t e;
          e = qa.pop_front();
          if ({a_out_immext, a_out_tag, a_out_illegal} !== {e.imm[31:0], e.tag, e.ill}) begin
            bad++;
            $display("FAIL a_beat: got imm=%h tag=%0d ill=%b, required imm=%h tag=%0d ill=%b",
                     a_out_immext, a_out_tag, a_out_illegal, e.imm[31:0], e.tag, e.ill);
          end
        end
      end
      if (a_flush) qa.delete();
      if (a_in_valid && a_in_ready && !a_flush)
        qa.push_back('{model(a_in_instr, a_in_immsrc, 1'b0), a_in_tag, a_in_immsrc == 3'b111});
    end
  end

  // Scoreboard B.
  always @(negedge clk) begin
    if (!reset_n) qb.delete();
    else begin
      if (b_out_valid && b_out_ready) begin
        total++;
        if (qb.size() == 0) begin
          bad++;
          $display("FAIL b_unexpected_beat: got imm=%h tag=%0d, required no beat", b_out_immext, b_out_tag);
        end else begin
          sb_t e;
          e = qb.pop_front();
          if ({b_out_immext, b_out_tag, b_out_illegal} !== {e.imm, e.tag, e.ill}) begin
            bad++;
            $display("FAIL b_beat: got imm=%h tag=%0d ill=%b, required imm=%h tag=%0d ill=%b",
                     b_out_immext, b_out_tag, b_out_illegal, e.imm, e.tag, e.ill);
          end
        end
      end
      if (b_flush) qb.delete();
      if (b_in_valid && b_in_ready && !b_flush)
        qb.push_back('{model(b_in_instr, b_in_immsrc, 1'b1), b_in_tag, b_in_immsrc == 3'b111});
    end
  end

  // Present a beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic push_a(input logic [24:0] ins, input logic [2:0] sel, input logic [4:0] tag);
    bit ok = 0;
    a_in_valid = 1; a_in_instr = ins; a_in_immsrc = sel; a_in_tag = tag;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (a_in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL a_accept_timeout: in_ready=%b, required 1 within 50 cycles", a_in_ready);
    end
    @(posedge clk); #1;
    a_in_valid = 0;
  endtask

  task automatic push_b(input logic [24:0] ins, input logic [2:0] sel, input logic [4:0] tag);
    bit ok = 0;
    b_in_valid = 1; b_in_instr = ins; b_in_immsrc = sel; b_in_tag = tag;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (b_in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL b_accept_timeout: in_ready=%b, required 1 within 50 cycles", b_in_ready);
    end
    @(posedge clk); #1;
    b_in_valid = 0;
  endtask

  task automatic test_reset();
    #1 reset_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (a_out_valid !== 1'b0)     begin bad++; $display("FAIL rst_a_valid: got %b, required 0", a_out_valid); end
    total++; if (a_out_immext !== 32'h0)   begin bad++; $display("FAIL rst_a_imm: got %h, required 0", a_out_immext); end
    total++; if (a_out_tag !== 5'h0)       begin bad++; $display("FAIL rst_a_tag: got %h, required 0", a_out_tag); end
    total++; if (a_out_illegal !== 1'b0)   begin bad++; $display("FAIL rst_a_ill: got %b, required 0", a_out_illegal); end
    total++; if (a_illegal_cnt !== 16'h0)  begin bad++; $display("FAIL rst_a_cnt: got %h, required 0", a_illegal_cnt); end
    total++; if (a_in_ready !== 1'b1)      begin bad++; $display("FAIL rst_a_ready: got %b, required 1", a_in_ready); end
    total++; if (b_out_valid !== 1'b0)     begin bad++; $display("FAIL rst_b_valid: got %b, required 0", b_out_valid); end
    total++; if (b_out_immext !== 64'h0)   begin bad++; $display("FAIL rst_b_imm: got %h, required 0", b_out_immext); end
    total++; if (b_illegal_cnt !== 16'h0)  begin bad++; $display("FAIL rst_b_cnt: got %h, required 0", b_illegal_cnt); end
    total++; if (b_in_ready !== 1'b1)      begin bad++; $display("FAIL rst_b_ready: got %b, required 1", b_in_ready); end
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_formats_a();
    logic [31:0] ins_t [4] = '{32'hFFF00093, 32'hFFDFF06F, 32'h123450B7, 32'h000A8073};
    logic [2:0]  sel_t [4] = '{3'd0, 3'd3, 3'd4, 3'd5};
    logic [31:0] exp_t [4] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h00000015};
    logic [31:0] w;
    a_out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      w = ins_t[k];
      push_a(w[31:7], sel_t[k], 5'(k + 1));
      @(negedge clk);
      total++;
      if (a_out_valid !== 1'b1 || a_out_immext !== exp_t[k] || a_out_illegal !== 1'b0) begin
        bad++;
        $display("FAIL fmt_a_%0d: got valid=%b imm=%h ill=%b, required valid=1 imm=%h ill=0",
                 k, a_out_valid, a_out_immext, a_out_illegal, exp_t[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random_a();
    bit done = 0;
    fork
      begin
        for (int k = 0; k < 25; k++)
          push_a(25'($urandom), 3'($urandom_range(0, 6)), 5'($urandom));
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          a_out_ready = 1'($urandom);
        end
      end
    join
    a_out_ready = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if (qa.size() != 0) begin bad++; $display("FAIL rand_a_drain: got %0d pending, required 0", qa.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back_a();
    a_out_ready = 1;
    fork
      begin
        a_in_valid = 1;
        for (int k = 0; k < 8; k++) begin
          a_in_instr = 25'($urandom); a_in_immsrc = 3'($urandom_range(0, 6)); a_in_tag = 5'(k);
          @(posedge clk); #1;
        end
        a_in_valid = 0;
      end
      begin
        @(negedge clk);
        repeat (8) begin
          @(negedge clk);
          total++;
          if (a_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_a_valid: got %b, required 1", a_out_valid); end
        end
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_formats_b();
    logic [31:0] w;
    bit done = 0;
    b_out_ready = 1;
    w = 32'hFFF00093;
    push_b(w[31:7], 3'd0, 5'd9);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (b_out_valid !== 1'b0) begin bad++; $display("FAIL lat_b_early_%0d: got valid=%b, required 0", k, b_out_valid); end
    end
    @(negedge clk);
    total++;
    if (b_out_valid !== 1'b1 || b_out_immext !== 64'hFFFFFFFFFFFFFFFF) begin
      bad++; $display("FAIL fmt_b_i: got valid=%b imm=%h, required valid=1 imm=ffffffffffffffff", b_out_valid, b_out_immext);
    end
    @(posedge clk); #1;
    w = 32'h02100013;
    push_b(w[31:7], 3'd6, 5'd10);
    repeat (3) @(negedge clk);
    total++;
    if (b_out_valid !== 1'b1 || b_out_immext !== 64'h21) begin
      bad++; $display("FAIL fmt_b_sh: got valid=%b imm=%h, required valid=1 imm=21", b_out_valid, b_out_immext);
    end
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 20; k++)
          push_b(25'($urandom), 3'($urandom_range(0, 6)), 5'($urandom));
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          b_out_ready = 1'($urandom);
        end
      end
    join
    b_out_ready = 1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++;
    if (qb.size() != 0) begin bad++; $display("FAIL rand_b_drain: got %0d pending, required 0", qb.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure_b();
    b_out_ready = 0;
    for (int k = 1; k <= 3; k++) push_b(25'($urandom), 3'($urandom_range(0, 6)), 5'(k));
    fork
      begin
        push_b(25'($urandom), 3'($urandom_range(0, 6)), 5'd4);
        push_b(25'($urandom), 3'($urandom_range(0, 6)), 5'd5);
      end
      begin
        @(negedge clk);
        total++;
        if (b_in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready: got %b, required 0", b_in_ready); end
        repeat (2) begin
          @(negedge clk);
          total++;
          if (b_out_valid !== 1'b1 || b_out_tag !== 5'd1) begin
            bad++; $display("FAIL bp_hold: got valid=%b tag=%0d, required valid=1 tag=1", b_out_valid, b_out_tag);
          end
        end
        @(posedge clk); #1;
        b_out_ready = 1;
        @(negedge clk);
        total++;
        if (b_in_ready !== 1'b1) begin bad++; $display("FAIL bp_shift_ready: got %b, required 1", b_in_ready); end
      end
    join
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++;
    if (qb.size() != 0) begin bad++; $display("FAIL bp_drain: got %0d pending, required 0", qb.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_b();
    int seen = 0;
    b_out_ready = 0;
    push_b(25'($urandom), 3'd0, 5'd11);
    push_b(25'($urandom), 3'd1, 5'd12);
    b_in_valid = 1; b_in_instr = 25'($urandom); b_in_immsrc = 3'd2; b_in_tag = 5'd13;
    b_flush = 1;
    @(posedge clk); #1;
    b_flush = 0; b_in_valid = 0;
    @(negedge clk);
    total++;
    if (b_out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b, required 0", b_out_valid); end
    @(posedge clk); #1;
    b_out_ready = 1;
    repeat (6) begin
      @(negedge clk);
      if (b_out_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL flush_leak: got %0d beats, required 0", seen); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_a();
    a_out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      push_a(25'($urandom), 3'd7, 5'(20 + k));
      @(negedge clk);
      total++;
      if (a_out_illegal !== 1'b1 || a_out_immext !== 32'h0) begin
        bad++; $display("FAIL ill_beat_%0d: got ill=%b imm=%h, required ill=1 imm=0", k, a_out_illegal, a_out_immext);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (a_illegal_cnt !== 16'd3) begin bad++; $display("FAIL ill_cnt3: got %0d, required 3", a_illegal_cnt); end
    @(posedge clk); #1;
    // Stream illegal beats until the counter sits one below saturation.
    a_in_valid = 1; a_in_immsrc = 3'd7; a_in_instr = 25'($urandom); a_in_tag = 5'd0;
    repeat (65531) @(posedge clk);
    #1 a_in_valid = 0;
    @(negedge clk);
    total++;
    if (a_illegal_cnt !== 16'hFFFE) begin bad++; $display("FAIL ill_cnt_pre: got %h, required fffe", a_illegal_cnt); end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) push_a(25'($urandom), 3'd7, 5'(k));
    @(negedge clk);
    total++;
    if (a_illegal_cnt !== 16'hFFFF) begin bad++; $display("FAIL ill_cnt_sat: got %h, required ffff", a_illegal_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    b_out_ready = 0;
    push_b(25'($urandom), 3'd4, 5'd7);
    push_b(25'($urandom), 3'd3, 5'd8);
    a_in_valid = 1; a_in_instr = 25'($urandom); a_in_immsrc = 3'd0; a_in_tag = 5'd3;
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    total++; if (a_out_valid !== 1'b0)    begin bad++; $display("FAIL mid_a_valid: got %b, required 0", a_out_valid); end
    total++; if (a_out_immext !== 32'h0)  begin bad++; $display("FAIL mid_a_imm: got %h, required 0", a_out_immext); end
    total++; if (a_illegal_cnt !== 16'h0) begin bad++; $display("FAIL mid_a_cnt: got %h, required 0", a_illegal_cnt); end
    total++; if (b_out_immext !== 64'h0)  begin bad++; $display("FAIL mid_b_imm: got %h, required 0", b_out_immext); end
    total++; if (b_out_tag !== 5'h0)      begin bad++; $display("FAIL mid_b_tag: got %h, required 0", b_out_tag); end
    a_in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    w = 32'hFFF00093;
    reset_n = 1;
    a_out_ready = 1; a_in_valid = 1; a_in_instr = w[31:7]; a_in_immsrc = 3'd0; a_in_tag = 5'd17;
    @(posedge clk); #1;
    a_in_valid = 0;
    @(negedge clk);
    total++;
    if (a_out_valid !== 1'b1 || a_out_immext !== 32'hFFFFFFFF || a_out_tag !== 5'd17) begin
      bad++; $display("FAIL post_rst_first: got valid=%b imm=%h tag=%0d, required valid=1 imm=ffffffff tag=17",
                      a_out_valid, a_out_immext, a_out_tag);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_formats_a();
    test_random_a();
    test_back_to_back_a();
    test_formats_b();
    test_backpressure_b();
    test_flush_b();
    test_illegal_a();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the decode stage of the RVX10 pipeline. Covers every RV32I/RV64I immediate format plus CSR zimm and shift amounts, and sign- or zero-extends each to XLEN. Results pass through a configurable-depth elastic register pipeline with valid/ready backpressure, flush, and a sideband tag. A saturating counter records undefined format selects.

## Interface
- XLEN, default 32: datapath width; legal values 32 or 64.
- STAGES, default 1: register stages between input and output; legal range 1..3.
- TAG_W, default 5: width of the opaque sideband tag (e.g. rd) carried alongside the immediate.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_instr  input  25  instruction bits [31:7].
- in_immsrc  input  3  format select (imm_src_e).
- in_tag  input  TAG_W  sideband, passed through unchanged.
- flush  input  1  synchronous kill of all in-flight beats.
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts the beat.
- out_immext  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the output beat.
- out_illegal  output  1  beat carried select 3'b111.
- illegal_cnt  output  16  saturating count of accepted illegal beats.

## Operation
- Format encoding of in_immsrc:
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25], instr[11:7]}).
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 011 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 100 U: sext({instr[31:12], 12'b0}), sign-extended from bit 31 when XLEN=64.
  - 101 Z: zext(instr[19:15]).
  - 110 SH: zext(instr[24:20]) when XLEN=32; zext(instr[25:20]) when XLEN=64.
  - 111: immext = 0, illegal = 1.
- Extension is computed combinationally at entry and registered into stage 0. Later stages carry {valid, immext, tag, illegal}.
- Elastic pipeline:
  - Stage i loads when it is empty or when its content moves onward this cycle.
  - The last stage moves when out_valid && out_ready.
  - in_ready is the load condition of stage 0, so it depends combinationally on out_ready through the chain.
- Accepted beat: in_valid && in_ready && !flush.
- flush clears every stage's valid bit at the next edge.
  - A beat presented in the same cycle as flush is dropped.
  - in_ready is unaffected by flush.
- illegal_cnt increments on each accepted beat with select 111, saturates at 16'hFFFF, and is not cleared by flush.
- Data registers of empty stages hold their previous values. Outputs are qualified only by out_valid.

## Timing
- Reset (asynchronous assertion): all valid bits 0, out_immext 0, out_tag 0, out_illegal 0, illegal_cnt 0. in_ready is 1 after reset.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES-1, i.e. first visible in the cycle after edge n+STAGES-1.
- Throughput: one beat per cycle while out_ready=1.
- Full pipeline (all STAGES valid) with out_ready=0: in_ready=0 and contents held.
- Full pipeline with out_ready=1: the pipeline shifts and accepts in the same cycle.
- Reset asserted mid-stream: all in-flight beats are lost and the counter clears. After deassertion the first accept takes place at the next edge.

## Structure
- Package imm_pkg:
  - imm_src_e enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_SH, IMM_BAD).
  - Stage payload struct.
  - Constant CNT_W = 16.
- Sub-module imm_ext_comb(XLEN): the pure combinational format decoder, instantiated once at entry.
- Stage registers are generated with a for-generate over STAGES inside imm_gen_pipe.

## Test plan
- XLEN=32, STAGES=1, IMM_I, instr 0xFFF00093 -> out_immext 0xFFFFFFFF one cycle later, out_illegal 0.
- IMM_J with 0xFFDFF06F -> 0xFFFFFFFC; IMM_U with 0x123450B7 -> 0x12345000; IMM_Z with 0x000A8073 -> 0x00000015.
- XLEN=64, IMM_I with 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF; IMM_SH with instr[25:20]=6'b100001 -> 0x21.
- STAGES=3, stream 5 beats with out_ready held 0 -> in_ready falls after 3 accepts; release out_ready -> all 5 beats emerge in order with correct tags, no loss and no duplication.
- flush asserted with 2 beats in flight and in_valid=1 -> out_valid=0 next cycle and no flushed beat ever emerges.
- 3 beats with select 111 -> out_immext 0, out_illegal 1, illegal_cnt=3. Preload the counter to 16'hFFFE and send 3 more -> it holds at 16'hFFFF. reset_n low mid-stream -> all outputs 0 asynchronously.
